// File: rtl/dmem_pkg.sv
// Shared encodings for the data memory responder: access sizes, FSM states
// and the wait-state counter width.
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE     = 2'b00;
  localparam logic [1:0] SIZE_HALF     = 2'b01;
  localparam logic [1:0] SIZE_WORD     = 2'b10;
  localparam logic [1:0] SIZE_WORD_ALT = 2'b11;

  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/dmem_lane_decode.sv
// Byte-enable and misalignment decode for one access.
// Misalignment is only reported when DMEM_ERR_CHECK_EN is defined.
module dmem_lane_decode
  import dmem_pkg::*;
(
  input  logic [1:0] size_i,
  input  logic [1:0] addr_lo_i,
  output logic [3:0] be_o,
  output logic       misalign_o
);

  // Lane selection from size and the low address bits
  always_comb begin
    be_o       = 4'b1111;
    misalign_o = 1'b0;
    case (size_i)
      SIZE_BYTE: be_o = 4'b0001 << addr_lo_i;
      SIZE_HALF: begin
        be_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
`ifdef DMEM_ERR_CHECK_EN
        misalign_o = addr_lo_i[0];
`endif
      end
      SIZE_WORD, SIZE_WORD_ALT: begin
        be_o = 4'b1111;
`ifdef DMEM_ERR_CHECK_EN
        misalign_o = (addr_lo_i != 2'b00);
`endif
      end
      default: be_o = 4'b1111;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Wait-state data memory responder: IDLE -> WAIT -> RESP handshake over a
// word array. Define DMEM_ERR_CHECK_EN to fault misaligned/out-of-range accesses.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST =
    WAIT_CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  ready_q, write_q, rsp_valid_q, rsp_err_q;
  logic [1:0]            size_q;
  logic [31:0]           addr_q, wdata_q, rsp_rdata_q;
  logic [31:0]           mem_q [DEPTH_WORDS];

  logic        accept_s, access_s, op_write_s, misalign_s, oob_s, err_s;
  logic [1:0]  op_size_s;
  logic [31:0] op_addr_s, op_wdata_s;
  logic [3:0]  be_s;
  logic [29:0] word_idx_s;
  logic [AW-1:0] mem_idx_s;

  assign accept_s = req_valid && ready_q;

  // With zero wait states the access happens on the accept edge, before the latches hold the request
  assign op_write_s = (state_q == ST_IDLE) ? req_write : write_q;
  assign op_size_s  = (state_q == ST_IDLE) ? req_size  : size_q;
  assign op_addr_s  = (state_q == ST_IDLE) ? req_addr  : addr_q;
  assign op_wdata_s = (state_q == ST_IDLE) ? req_wdata : wdata_q;

  assign word_idx_s = op_addr_s[31:2];
  assign mem_idx_s  = AW'(word_idx_s % 30'(DEPTH_WORDS));
`ifdef DMEM_ERR_CHECK_EN
  assign oob_s = (word_idx_s >= 30'(DEPTH_WORDS));
`else
  assign oob_s = 1'b0;
`endif
  assign err_s = misalign_s | oob_s;

  dmem_lane_decode u_lane_decode (
    .size_i     (op_size_s),
    .addr_lo_i  (op_addr_s[1:0]),
    .be_o       (be_s),
    .misalign_o (misalign_s)
  );

  // Next-state logic; access_s marks the edge that enters RESP
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    access_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = {WAIT_CNT_W{1'b0}};
        if (accept_s) begin
          if (WAIT_CYCLES == 0) begin
            state_d  = ST_RESP;
            access_s = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d  = ST_RESP;
          access_s = 1'b1;
        end else begin
          cnt_d = cnt_q + WAIT_CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        cnt_d   = {WAIT_CNT_W{1'b0}};
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {WAIT_CNT_W{1'b0}};
      end
    endcase
  end

  // FSM state and registered response outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {WAIT_CNT_W{1'b0}};
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= (state_d == ST_IDLE);
      rsp_valid_q <= access_s;
      rsp_err_q   <= access_s & err_s;
      rsp_rdata_q <= (access_s && !op_write_s && !err_s) ? mem_q[mem_idx_s] : 32'h0000_0000;
    end
  end

  // Request capture on accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_q <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
    end else if (accept_s) begin
      write_q <= req_write;
      size_q  <= req_size;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Storage is deliberately outside reset so contents survive it
  always_ff @(posedge clk) begin
    if (access_s && op_write_s && !err_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_q[mem_idx_s][8*i +: 8] <= op_wdata_s[8*i +: 8];
        end
      end
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder (WAIT_CYCLES=1 main instance,
// WAIT_CYCLES=0 instance for back-to-back throughput); honours DMEM_ERR_CHECK_EN.
module tb_data_mem_responder;

`ifdef DMEM_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        valid0 = 1'b0, write0 = 1'b0;
  logic [1:0]  size0 = 2'b10;
  logic [31:0] addr0 = 32'h0, wdata0 = 32'h0;
  logic        ready0, rsp_valid0, rsp_err0;
  logic [31:0] rsp_rdata0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   q0[$];
  exp_t e;
  int   checks = 0, failures = 0, cyc = 0;
  logic prev_v = 1'b0, prev_v0 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) dut (
    .clk(clk), .reset(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(rst_n), .req_valid(valid0), .req_ready(ready0),
    .req_write(write0), .req_size(size0), .req_addr(addr0), .req_wdata(wdata0),
    .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Main monitor: pops the scoreboard on every response
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      check("rsp_single_cycle", {31'b0, prev_v}, 32'h0);
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response");
      end else begin
        e = q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        check("rsp_latency", cyc, e.cyc);
      end
    end else if (rsp_valid === 1'b0) begin
      check("idle_rdata_zero", rsp_rdata, 32'h0);
      check("idle_err_zero", {31'b0, rsp_err}, 32'h0);
    end
    prev_v = rsp_valid;
  end

  // Zero-wait instance monitor
  always @(negedge clk) begin
    if (rsp_valid0 === 1'b1) begin
      check("rsp0_single_cycle", {31'b0, prev_v0}, 32'h0);
      if (q0.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp0_unexpected: got rsp_valid=1 expected no response");
      end else begin
        check("rsp0_latency", cyc, q0.pop_front());
        check("rsp0_rdata", rsp_rdata0, 32'h0);
        check("rsp0_err", {31'b0, rsp_err0}, 32'h0);
      end
    end
    prev_v0 = rsp_valid0;
  end

  task automatic do_req(input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee,
                        input bit abort);
    int n;
    exp_t x;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_addr = a; req_wdata = wd;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got req_ready=%b expected 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    x.rdata = er; x.err = ee; x.cyc = cyc + 2;
    if (!abort) q.push_back(x);
    @(posedge clk);
    #1;
    // Scramble inputs after accept: the latched request must be used
    req_valid = 1'b0; req_write = ~w; req_size = 2'b00;
    req_addr = 32'hFFFF_FFFD; req_wdata = 32'hA5A5_A5A5;
    if (abort) return;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL rsp_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    int acc;
    logic prev_r0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("reset_ready", {31'b0, req_ready}, 32'h0);
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("reset_rdata", rsp_rdata, 32'h0);
    check("reset_err", {31'b0, rsp_err}, 32'h0);
    rst_n = 1'b1;
    #1 check("ready_low_before_edge", {31'b0, req_ready}, 32'h0);
    @(negedge clk);
    check("ready_after_release", {31'b0, req_ready}, 32'h1);

    do_req(1'b1, 2'b10, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
    do_req(1'b0, 2'b10, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    do_req(1'b1, 2'b10, 32'h10, 32'h1122_3344, 32'h0, 1'b0, 1'b0);
    do_req(1'b1, 2'b00, 32'h11, 32'h0000_AA00, 32'h0, 1'b0, 1'b0);
    do_req(1'b0, 2'b10, 32'h10, 32'h0, 32'h1122_AA44, 1'b0, 1'b0);
    do_req(1'b0, 2'b00, 32'h12, 32'h0, 32'h1122_AA44, 1'b0, 1'b0);

    do_req(1'b1, 2'b10, 32'h20, 32'h5566_7788, 32'h0, 1'b0, 1'b0);
    do_req(1'b1, 2'b01, 32'h23, 32'hCCDD_0000, 32'h0, ERR_EN, 1'b0);
    do_req(1'b0, 2'b10, 32'h20, 32'h0, ERR_EN ? 32'h5566_7788 : 32'hCCDD_7788, 1'b0, 1'b0);
    do_req(1'b1, 2'b01, 32'h22, 32'h99AA_0000, 32'h0, 1'b0, 1'b0);
    do_req(1'b0, 2'b10, 32'h20, 32'h0, 32'h99AA_7788, 1'b0, 1'b0);

    do_req(1'b1, 2'b10, 32'h0, 32'h0102_0304, 32'h0, 1'b0, 1'b0);
    do_req(1'b1, 2'b10, 32'h400, 32'hCAFE_F00D, 32'h0, ERR_EN, 1'b0);
    do_req(1'b0, 2'b10, 32'h0, 32'h0, ERR_EN ? 32'h0102_0304 : 32'hCAFE_F00D, 1'b0, 1'b0);
    do_req(1'b0, 2'b10, 32'h400, 32'h0, ERR_EN ? 32'h0 : 32'hCAFE_F00D, ERR_EN, 1'b0);

    do_req(1'b1, 2'b11, 32'h40, 32'hA1B2_C3D4, 32'h0, 1'b0, 1'b0);
    do_req(1'b0, 2'b11, 32'h40, 32'h0, 32'hA1B2_C3D4, 1'b0, 1'b0);

    // Reset during the wait state of a store
    do_req(1'b1, 2'b10, 32'h30, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
    do_req(1'b1, 2'b10, 32'h30, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #2 check("midreset_ready", {31'b0, req_ready}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_one_edge_after_release", {31'b0, req_ready}, 32'h1);
    do_req(1'b0, 2'b10, 32'h30, 32'h0, 32'h1234_5678, 1'b0, 1'b0);

    // Back-to-back requests on the zero-wait instance
    @(negedge clk);
    valid0 = 1'b1; write0 = 1'b1; size0 = 2'b10; addr0 = 32'h0; wdata0 = 32'h0;
    acc = 0;
    prev_r0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (ready0 === 1'b1) begin
        acc++;
        q0.push_back(cyc + 1);
      end
      if (i > 0) check("ready0_alternates", {31'b0, ready0}, {31'b0, ~prev_r0});
      prev_r0 = ready0;
      @(negedge clk);
    end
    valid0 = 1'b0;
    check("accepts_in_10_cycles", acc, 32'd5);
    for (int n = 0; n < 5 && q0.size() != 0; n++) @(negedge clk);
    check("rsp0_pending", q0.size(), 32'd0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
